// File: rtl/serial_borrow_subtractor.sv
// serial_borrow_subtractor
// Bit-serial ripple-borrow subtractor: D = A - B - Bin, one bit per clock,
// LSB first, built from a single full-subtractor cell and a borrow flip-flop.
// A start/busy/done handshake frames each operation, and the result registers
// hold the previous difference until the next operation completes.
//
// Optional feature: define SERIAL_SUB_SIGNED_OVF_EN to add the 'ovf' output.
// It is a signed two's-complement overflow flag that is loaded together with D.
module serial_borrow_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  // The counter is kept at least one bit wide so that WIDTH = 1 still elaborates.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;
  logic             r_brw;
  logic             r_bout;
  logic             r_done;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic             r_aMsb;
  logic             r_bMsb;
  logic             r_ovf;
`endif

  // Full-subtractor cell operating on the current LSBs of the operand registers.
  logic             w_ai;
  logic             w_bi;
  logic             w_di;
  logic             w_brwNext;
  logic [WIDTH:0]   w_resWide;
  logic [WIDTH-1:0] w_resNext;
  logic             w_lastBit;

  assign w_ai      = r_a[0];
  assign w_bi      = r_b[0];
  assign w_di      = w_ai ^ w_bi ^ r_brw;
  assign w_brwNext = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_brw);

  // The new difference bit enters from the MSB end. Building a WIDTH+1 wide
  // word and dropping its LSB avoids an empty slice when WIDTH = 1.
  assign w_resWide = {w_di, r_res};
  assign w_resNext = w_resWide[WIDTH:1];
  assign w_lastBit = (r_cnt == LAST_BIT);

  // Sequencing, operand capture, bit-serial datapath and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_brw   <= 1'b0;
      r_bout  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      r_aMsb  <= 1'b0;
      r_bMsb  <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_brw   <= Bin;
            r_res   <= '0;
            r_cnt   <= '0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            r_aMsb  <= A[WIDTH-1];
            r_bMsb  <= B[WIDTH-1];
`endif
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_brw <= w_brwNext;
          r_res <= w_resNext;
          r_cnt <= r_cnt + 1'b1;
          if (w_lastBit) begin
            r_d     <= w_resNext;
            r_bout  <= w_brwNext;
            r_done  <= 1'b1;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            r_ovf   <= (r_aMsb != r_bMsb) && (w_resNext[WIDTH-1] != r_aMsb);
`endif
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign D    = r_d;
  assign Bout = r_bout;
  assign done = r_done;
  assign busy = (r_state == RUN);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// tb_serial_borrow_subtractor
// Directed and random checks of serial_borrow_subtractor against a plain
// arithmetic model of A - B - Bin. The optional ovf port is connected and
// checked when SERIAL_SUB_SIGNED_OVF_EN is defined.
module tb_serial_borrow_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic [W-1:0] D;
  logic         Bout;
  logic         busy;
  logic         done;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic         ovf;
`endif

  int assertCount;
  int failCount;

  // The model's view of what the result registers currently hold.
  logic [W-1:0] holdD;
  logic         holdBout;
  logic         holdOvf;

  serial_borrow_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .D     (D),
    .Bout  (Bout),
    .busy  (busy),
    .done  (done)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock step; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Presents an operation so that it is accepted at the next rising edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    start = 1'b1;
    A     = a;
    B     = b;
    Bin   = bin;
  endtask

  // Runs an operation that is already presented on the inputs. glitchStart
  // raises start in the middle of RUN with other operands. When chain is set,
  // the next operation is presented during the done cycle; otherwise the
  // cycle after done is checked for an idle, pulse-free state.
  task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       input bit glitchStart, input bit chain,
                       input logic [W-1:0] na, input logic [W-1:0] nb, input logic nbin);
    int           diff;
    logic [W-1:0] expD;
    logic         expBout;
    logic         expOvf;

    diff    = int'(a) - int'(b) - int'(bin);
    expD    = diff[W-1:0];
    expBout = (int'(a) < (int'(b) + int'(bin)));
    expOvf  = (a[W-1] != b[W-1]) && (expD[W-1] != a[W-1]);

    tick();
    start = 1'b0;
    A     = W'($urandom);
    B     = W'($urandom);
    Bin   = 1'($urandom);
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    checkOutput("done_after_start", 32'(done), 32'd0);

    for (int k = 1; k < W; k++) begin
      tick();
      if (glitchStart && (k == 1)) begin
        start = 1'b1;
        A     = 4'd1;
        B     = 4'd1;
        Bin   = 1'b0;
      end else begin
        start = 1'b0;
        A     = W'($urandom);
        B     = W'($urandom);
      end
      checkOutput("busy_run", 32'(busy), 32'd1);
      checkOutput("done_run", 32'(done), 32'd0);
      checkOutput("D_hold_run", 32'(D), 32'(holdD));
      checkOutput("Bout_hold_run", 32'(Bout), 32'(holdBout));
    end

    start = 1'b0;
    tick();
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("busy_end", 32'(busy), 32'd0);
    checkOutput("D_result", 32'(D), 32'(expD));
    checkOutput("Bout_result", 32'(Bout), 32'(expBout));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    checkOutput("ovf_result", 32'(ovf), 32'(expOvf));
`endif
    holdD    = expD;
    holdBout = expBout;
    holdOvf  = expOvf;

    if (chain) begin
      applyStimulus(na, nb, nbin);
    end else begin
      tick();
      checkOutput("done_single_cycle", 32'(done), 32'd0);
      checkOutput("busy_idle", 32'(busy), 32'd0);
      checkOutput("D_idle", 32'(D), 32'(holdD));
    end
  endtask

  // Directed scenarios followed by random and back-to-back operations.
  initial begin
    logic         sawDone;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rbin;
    logic [W-1:0] na;
    logic [W-1:0] nb;
    logic         nbin;

    assertCount = 0;
    failCount   = 0;
    holdD       = '0;
    holdBout    = 1'b0;
    holdOvf     = 1'b0;
    rst_n       = 1'b0;
    start       = 1'b0;
    A           = '0;
    B           = '0;
    Bin         = 1'b0;

    #1;
    checkOutput("reset_D", 32'(D), 32'd0);
    checkOutput("reset_Bout", 32'(Bout), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    checkOutput("reset_ovf", 32'(ovf), 32'd0);
`endif
    #12;
    rst_n = 1'b1;
    tick();
    tick();
    checkOutput("idle_no_start_busy", 32'(busy), 32'd0);

    $display("[TB] basic subtraction 9 - 3");
    applyStimulus(4'd9, 4'd3, 1'b0);
    runOp(4'd9, 4'd3, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

    $display("[TB] negative result 3 - 9 and hold");
    applyStimulus(4'd3, 4'd9, 1'b0);
    runOp(4'd3, 4'd9, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("hold_D_idle", 32'(D), 32'hA);
      checkOutput("hold_done_idle", 32'(done), 32'd0);
    end

    $display("[TB] borrow-in wrap 0 - 0 - 1");
    applyStimulus(4'd0, 4'd0, 1'b1);
    runOp(4'd0, 4'd0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);

    $display("[TB] start ignored in RUN, accepted in done cycle");
    applyStimulus(4'd12, 4'd5, 1'b0);
    runOp(4'd12, 4'd5, 1'b0, 1'b1, 1'b1, 4'd1, 4'd1, 1'b0);
    runOp(4'd1, 4'd1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

    $display("[TB] signed overflow cases");
    applyStimulus(4'd7, 4'hF, 1'b0);
    runOp(4'd7, 4'hF, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    applyStimulus(4'd5, 4'd3, 1'b0);
    runOp(4'd5, 4'd3, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

    $display("[TB] reset mid-operation");
    applyStimulus(4'd15, 4'd1, 1'b0);
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("abort_D", 32'(D), 32'd0);
    checkOutput("abort_Bout", 32'(Bout), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    checkOutput("abort_ovf", 32'(ovf), 32'd0);
`endif
    holdD    = '0;
    holdBout = 1'b0;
    holdOvf  = 1'b0;
    #2;
    rst_n   = 1'b1;
    sawDone = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      sawDone = sawDone | done | busy;
    end
    checkOutput("abort_no_done", 32'(sawDone), 32'd0);

    $display("[TB] random operations, some back-to-back");
    ra   = W'($urandom);
    rb   = W'($urandom);
    rbin = 1'($urandom);
    applyStimulus(ra, rb, rbin);
    for (int i = 0; i < 40; i++) begin
      na   = W'($urandom);
      nb   = W'($urandom);
      nbin = 1'($urandom);
      if ((i % 3) == 0) begin
        runOp(ra, rb, rbin, 1'b0, 1'b0, '0, '0, 1'b0);
        applyStimulus(na, nb, nbin);
      end else begin
        runOp(ra, rb, rbin, 1'($urandom_range(1, 0)), 1'b1, na, nb, nbin);
      end
      ra   = na;
      rb   = nb;
      rbin = nbin;
    end
    runOp(ra, rb, rbin, 1'b0, 1'b0, '0, '0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
